mst_fsm: RTL and testbench

MST_FSM -- requirements
Module: mst_fsm

---
 rtl/mst_fsm_if.sv | 39 +++
 rtl/mst_fsm.sv | 129 ++++++++++++
 tb/tb_mst_fsm.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mst_fsm_if.sv
// Request/acknowledge bundle between the upstream requester, the mst_fsm bridge and
// the downstream slave. The bridge takes the master view; the environment takes the slave view.
interface mst_fsm_if #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  mst_req_vld;
    logic                  mst_req_rdy;
    logic                  mst_wr_en;
    logic                  mst_rd_en;
    logic [ADDR_WIDTH-1:0] mst_addr;
    logic [DATA_WIDTH-1:0] mst_wr_data;
    logic                  mst_ack_vld;
    logic [DATA_WIDTH-1:0] mst_rd_data;
    logic                  mst_err;
    logic                  if_req_vld;
    logic                  if_wr_en;
    logic                  if_rd_en;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [DATA_WIDTH-1:0] if_wr_data;
    logic                  if_ack_vld;
    logic [DATA_WIDTH-1:0] if_rd_data;
    logic                  if_err;
    logic                  if_soft_rst;

    modport master (
        input  mst_req_vld, mst_wr_en, mst_rd_en, mst_addr, mst_wr_data,
        input  if_ack_vld, if_rd_data, if_err,
        output mst_req_rdy, mst_ack_vld, mst_rd_data, mst_err,
        output if_req_vld, if_wr_en, if_rd_en, if_addr, if_wr_data, if_soft_rst
    );

    modport slave (
        output mst_req_vld, mst_wr_en, mst_rd_en, mst_addr, mst_wr_data,
        output if_ack_vld, if_rd_data, if_err,
        input  mst_req_rdy, mst_ack_vld, mst_rd_data, mst_err,
        input  if_req_vld, if_wr_en, if_rd_en, if_addr, if_wr_data, if_soft_rst
    );
endinterface

// File: rtl/mst_fsm.sv
// Single-outstanding request bridge: latches an upstream request, issues it downstream,
// waits for the acknowledge (with optional timeout and soft-reset abort), returns a response.
module mst_fsm #(
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input logic       clk,
    input logic       rst,
    mst_fsm_if.master bus_io
);
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StReq     = 3'd1,
        StWait    = 3'd2,
        StTimeout = 3'd3,
        StResp    = 3'd4
    } state_e;

    localparam bit          TimeoutEn = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] CntLast   = TimeoutEn ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;

    state_e                state_q;
    logic                  wr_q;
    logic                  rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  drive_q;
    logic                  req_pulse_q;
    logic                  soft_rst_q;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [31:0]           cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wr_q        <= 1'b0;
            rd_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            req_pulse_q <= 1'b0;
            soft_rst_q  <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            req_pulse_q <= 1'b0;
            soft_rst_q  <= 1'b0;
            ack_q       <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus_io.mst_req_vld) begin
                        wr_q    <= bus_io.mst_wr_en;
                        rd_q    <= bus_io.mst_rd_en;
                        addr_q  <= bus_io.mst_addr;
                        wdata_q <= bus_io.mst_wr_data;
                        if (bus_io.mst_wr_en ^ bus_io.mst_rd_en) begin
                            state_q     <= StReq;
                            req_pulse_q <= 1'b1;
                            drive_q     <= 1'b1;
                        end else begin
                            // Malformed request: answer with an error, never touch downstream
                            state_q <= StResp;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                            rdata_q <= '0;
                        end
                    end
                end
                StReq: begin
                    state_q <= StWait;
                    cnt_q   <= '0;
                end
                StWait: begin
                    if (bus_io.if_ack_vld) begin
                        state_q <= StResp;
                        drive_q <= 1'b0;
                        ack_q   <= 1'b1;
                        err_q   <= bus_io.if_err;
                        rdata_q <= rd_q ? bus_io.if_rd_data : '0;
                    end else if (TimeoutEn && (cnt_q == CntLast)) begin
                        state_q    <= StTimeout;
                        drive_q    <= 1'b0;
                        soft_rst_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 32'd1;
                    end
                end
                StTimeout: begin
                    state_q <= StResp;
                    ack_q   <= 1'b1;
                    err_q   <= 1'b1;
                    rdata_q <= '0;
                end
                StResp: begin
                    state_q <= StIdle;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                end
                default: begin
                    state_q <= StIdle;
                    drive_q <= 1'b0;
                    err_q   <= 1'b0;
                    rdata_q <= '0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Every output is forced low while reset is held, not just after the reset edge
    logic run;
    assign run = ~rst;

    assign bus_io.mst_req_rdy = run & (state_q == StIdle);
    assign bus_io.mst_ack_vld = run & ack_q;
    assign bus_io.mst_err     = run & err_q;
    assign bus_io.mst_rd_data = run ? rdata_q : '0;
    assign bus_io.if_req_vld  = run & req_pulse_q;
    assign bus_io.if_wr_en    = run & drive_q & wr_q;
    assign bus_io.if_rd_en    = run & drive_q & rd_q;
    assign bus_io.if_addr     = (run & drive_q) ? addr_q : '0;
    assign bus_io.if_wr_data  = (run & drive_q) ? wdata_q : '0;
    assign bus_io.if_soft_rst = run & soft_rst_q;
endmodule

// File: tb/tb_mst_fsm.sv
// Directed bench for mst_fsm: one instance with the default timeout and one with a
// 4-cycle timeout share the stimulus; sel picks which instance each scenario observes.
module tb_mst_fsm;
    localparam int unsigned AW = 64;
    localparam int unsigned DW = 32;

    logic          clk;
    logic          rst;
    logic          req_vld;
    logic          wr_en;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack_vld;
    logic [DW-1:0] rdata;
    logic          err;
    logic          sel;

    int checks;
    int failures;

    mst_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_a ();
    mst_fsm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) if_b ();

    assign if_a.mst_req_vld = req_vld;
    assign if_a.mst_wr_en   = wr_en;
    assign if_a.mst_rd_en   = rd_en;
    assign if_a.mst_addr    = addr;
    assign if_a.mst_wr_data = wdata;
    assign if_a.if_ack_vld  = ack_vld;
    assign if_a.if_rd_data  = rdata;
    assign if_a.if_err      = err;
    assign if_b.mst_req_vld = req_vld;
    assign if_b.mst_wr_en   = wr_en;
    assign if_b.mst_rd_en   = rd_en;
    assign if_b.mst_addr    = addr;
    assign if_b.mst_wr_data = wdata;
    assign if_b.if_ack_vld  = ack_vld;
    assign if_b.if_rd_data  = rdata;
    assign if_b.if_err      = err;

    mst_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(256)) u_dut_a (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if_a.master)
    );

    mst_fsm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) u_dut_b (
        .clk    (clk),
        .rst    (rst),
        .bus_io (if_b.master)
    );

    logic          o_rdy, o_ack, o_err, o_ireq, o_iwr, o_ird, o_srst;
    logic [AW-1:0] o_iaddr;
    logic [DW-1:0] o_rdata, o_iwdata;

    assign o_rdy    = sel ? if_b.mst_req_rdy : if_a.mst_req_rdy;
    assign o_ack    = sel ? if_b.mst_ack_vld : if_a.mst_ack_vld;
    assign o_err    = sel ? if_b.mst_err     : if_a.mst_err;
    assign o_rdata  = sel ? if_b.mst_rd_data : if_a.mst_rd_data;
    assign o_ireq   = sel ? if_b.if_req_vld  : if_a.if_req_vld;
    assign o_iwr    = sel ? if_b.if_wr_en    : if_a.if_wr_en;
    assign o_ird    = sel ? if_b.if_rd_en    : if_a.if_rd_en;
    assign o_iaddr  = sel ? if_b.if_addr     : if_a.if_addr;
    assign o_iwdata = sel ? if_b.if_wr_data  : if_a.if_wr_data;
    assign o_srst   = sel ? if_b.if_soft_rst : if_a.if_soft_rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_vld = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = '0;
        wdata   = '0;
        ack_vld = 1'b0;
        rdata   = '0;
        err     = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle_inputs();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst = 1'b1;
        req_vld = 1'b1;
        wr_en   = 1'b1;
        addr    = 64'hFF;
        tick();
        #1;
        checks++; if (o_rdy !== 1'b0) begin failures++; $display("FAIL rst_rdy: got %0h want 0", o_rdy); end
        checks++; if (o_ack !== 1'b0) begin failures++; $display("FAIL rst_ack: got %0h want 0", o_ack); end
        checks++; if (o_ireq !== 1'b0 || o_iwr !== 1'b0 || o_ird !== 1'b0 || o_srst !== 1'b0) begin
            failures++; $display("FAIL rst_if_ctl: got %0h%0h%0h%0h want 0000", o_ireq, o_iwr, o_ird, o_srst);
        end
        checks++; if (o_iaddr !== '0 || o_rdata !== '0) begin
            failures++; $display("FAIL rst_data: got addr %0h rdata %0h want 0", o_iaddr, o_rdata);
        end
        tick();
        rst = 1'b0;
        idle_inputs();
        rd_en   = 1'b1;
        req_vld = 1'b1;
        addr    = 64'h99;
        #1;
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_first_rdy: got %0h want 1", o_rdy); end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1 || o_iaddr !== 64'h99) begin
            failures++; $display("FAIL rst_first_req: got vld %0h addr %0h want 1 99", o_ireq, o_iaddr);
        end
    endtask

    task automatic test_write();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; wr_en = 1'b1; addr = 64'h10; wdata = 32'hA5A5_0001;
        #1;
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL wr_rdy: got %0h want 1", o_rdy); end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1) begin failures++; $display("FAIL wr_if_req: got %0h want 1", o_ireq); end
        checks++; if (o_iwr !== 1'b1 || o_ird !== 1'b0) begin
            failures++; $display("FAIL wr_if_en: got wr %0h rd %0h want 1 0", o_iwr, o_ird);
        end
        checks++; if (o_iaddr !== 64'h10) begin failures++; $display("FAIL wr_if_addr: got %0h want 10", o_iaddr); end
        checks++; if (o_iwdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL wr_if_data: got %0h want a5a50001", o_iwdata);
        end
        tick();
        ack_vld = 1'b1; rdata = 32'h1234_5678;
        #1;
        checks++; if (o_ireq !== 1'b0) begin failures++; $display("FAIL wr_if_req_pulse: got %0h want 0", o_ireq); end
        checks++; if (o_iwdata !== 32'hA5A5_0001) begin
            failures++; $display("FAIL wr_if_data_ack: got %0h want a5a50001", o_iwdata);
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b0) begin
            failures++; $display("FAIL wr_resp: got ack %0h err %0h want 1 0", o_ack, o_err);
        end
        checks++; if (o_rdata !== '0) begin failures++; $display("FAIL wr_rdata: got %0h want 0", o_rdata); end
        checks++; if (o_iwr !== 1'b0 || o_iaddr !== '0) begin
            failures++; $display("FAIL wr_if_resp_idle: got wr %0h addr %0h want 0 0", o_iwr, o_iaddr);
        end
        tick();
        #1;
        checks++; if (o_ack !== 1'b0 || o_rdy !== 1'b1) begin
            failures++; $display("FAIL wr_back_idle: got ack %0h rdy %0h want 0 1", o_ack, o_rdy);
        end
    endtask

    task automatic test_read_wait();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h20;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1 || o_ird !== 1'b1 || o_iaddr !== 64'h20) begin
            failures++; $display("FAIL rd_req: got vld %0h rd %0h addr %0h want 1 1 20", o_ireq, o_ird, o_iaddr);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++; if (o_ack !== 1'b0) begin failures++; $display("FAIL rd_wait_noack: got %0h want 0", o_ack); end
        end
        tick();
        ack_vld = 1'b1; rdata = 32'hDEAD_BEEF;
        #1;
        checks++; if (o_ird !== 1'b1) begin failures++; $display("FAIL rd_en_ack: got %0h want 1", o_ird); end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL rd_resp: got ack %0h err %0h data %0h want 1 0 deadbeef", o_ack, o_err, o_rdata);
        end
        tick();
        #1;
        checks++; if (o_ack !== 1'b0 || o_rdata !== '0) begin
            failures++; $display("FAIL rd_post_resp: got ack %0h data %0h want 0 0", o_ack, o_rdata);
        end
    endtask

    task automatic test_read_err();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'hBAD0;
        tick();
        idle_inputs();
        tick();
        ack_vld = 1'b1; err = 1'b1; rdata = '0;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b1 || o_rdata !== '0) begin
            failures++; $display("FAIL err_resp: got ack %0h err %0h data %0h want 1 1 0", o_ack, o_err, o_rdata);
        end
        tick();
        #1;
        checks++; if (o_err !== 1'b0) begin failures++; $display("FAIL err_clear: got %0h want 0", o_err); end
    endtask

    task automatic test_timeout();
        sel = 1'b1;
        apply_reset();
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h30;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1) begin failures++; $display("FAIL to_req: got %0h want 1", o_ireq); end
        for (int i = 0; i < 4; i++) begin
            tick();
            #1;
            checks++; if (o_srst !== 1'b0) begin failures++; $display("FAIL to_early_srst: got %0h want 0", o_srst); end
        end
        tick();
        #1;
        checks++; if (o_srst !== 1'b1 || o_ack !== 1'b0) begin
            failures++; $display("FAIL to_srst: got srst %0h ack %0h want 1 0", o_srst, o_ack);
        end
        tick();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b1 || o_rdata !== '0 || o_srst !== 1'b0) begin
            failures++; $display("FAIL to_resp: got ack %0h err %0h data %0h srst %0h want 1 1 0 0",
                                 o_ack, o_err, o_rdata, o_srst);
        end
        tick();
        ack_vld = 1'b1; rdata = 32'h77;
        #1;
        checks++; if (o_ack !== 1'b0 || o_rdy !== 1'b1) begin
            failures++; $display("FAIL to_late_ack: got ack %0h rdy %0h want 0 1", o_ack, o_rdy);
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b0 || o_ireq !== 1'b0 || o_err !== 1'b0) begin
            failures++; $display("FAIL to_late_ignored: got ack %0h req %0h err %0h want 0 0 0", o_ack, o_ireq, o_err);
        end
    endtask

    task automatic test_illegal();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 64'h44;
        tick();
        wr_en = 1'b0; addr = 64'h40;
        #1;
        checks++; if (o_ireq !== 1'b0 || o_ack !== 1'b1 || o_err !== 1'b1 || o_rdy !== 1'b0) begin
            failures++; $display("FAIL ill_both: got req %0h ack %0h err %0h rdy %0h want 0 1 1 0",
                                 o_ireq, o_ack, o_err, o_rdy);
        end
        tick();
        #1;
        checks++; if (o_rdy !== 1'b1 || o_ack !== 1'b0) begin
            failures++; $display("FAIL ill_next_rdy: got rdy %0h ack %0h want 1 0", o_rdy, o_ack);
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1 || o_ird !== 1'b1 || o_iaddr !== 64'h40) begin
            failures++; $display("FAIL ill_next_req: got vld %0h rd %0h addr %0h want 1 1 40", o_ireq, o_ird, o_iaddr);
        end
        tick();
        ack_vld = 1'b1; rdata = 32'h0BAD_F00D;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_rdata !== 32'h0BAD_F00D || o_err !== 1'b0) begin
            failures++; $display("FAIL ill_next_resp: got ack %0h data %0h err %0h want 1 badf00d 0", o_ack, o_rdata, o_err);
        end
        tick();
        req_vld = 1'b1;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b1 || o_ireq !== 1'b0 || o_iwr !== 1'b0 || o_ird !== 1'b0) begin
            failures++; $display("FAIL ill_neither: got ack %0h err %0h req %0h wr %0h rd %0h want 1 1 0 0 0",
                                 o_ack, o_err, o_ireq, o_iwr, o_ird);
        end
    endtask

    task automatic test_back_to_back();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; wr_en = 1'b1; addr = 64'h50; wdata = 32'h1111_2222;
        tick();
        wr_en = 1'b0; rd_en = 1'b1; addr = 64'h60; wdata = 32'h3333;
        #1;
        checks++; if (o_rdy !== 1'b0 || o_iaddr !== 64'h50) begin
            failures++; $display("FAIL b2b_busy_req: got rdy %0h addr %0h want 0 50", o_rdy, o_iaddr);
        end
        tick();
        ack_vld = 1'b1;
        #1;
        checks++; if (o_rdy !== 1'b0 || o_iwr !== 1'b1 || o_iwdata !== 32'h1111_2222 || o_iaddr !== 64'h50) begin
            failures++; $display("FAIL b2b_busy_wait: got rdy %0h wr %0h data %0h addr %0h want 0 1 11112222 50",
                                 o_rdy, o_iwr, o_iwdata, o_iaddr);
        end
        tick();
        ack_vld = 1'b0;
        #1;
        checks++; if (o_ack !== 1'b1 || o_rdy !== 1'b0) begin
            failures++; $display("FAIL b2b_busy_resp: got ack %0h rdy %0h want 1 0", o_ack, o_rdy);
        end
        tick();
        #1;
        checks++; if (o_rdy !== 1'b1) begin failures++; $display("FAIL b2b_rdy: got %0h want 1", o_rdy); end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ireq !== 1'b1 || o_iaddr !== 64'h60 || o_ird !== 1'b1 || o_iwr !== 1'b0) begin
            failures++; $display("FAIL b2b_second_req: got vld %0h addr %0h rd %0h wr %0h want 1 60 1 0",
                                 o_ireq, o_iaddr, o_ird, o_iwr);
        end
        tick();
        ack_vld = 1'b1; rdata = 32'hCAFE_0001;
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_rdata !== 32'hCAFE_0001) begin
            failures++; $display("FAIL b2b_second_resp: got ack %0h data %0h want 1 cafe0001", o_ack, o_rdata);
        end
    endtask

    task automatic test_reset_mid();
        sel = 1'b0;
        apply_reset();
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h70;
        tick();
        idle_inputs();
        tick();
        #1;
        checks++; if (o_ird !== 1'b1) begin failures++; $display("FAIL rm_wait_rd: got %0h want 1", o_ird); end
        rst = 1'b1;
        #1;
        checks++; if (o_ird !== 1'b0 || o_iaddr !== '0 || o_rdy !== 1'b0) begin
            failures++; $display("FAIL rm_during: got rd %0h addr %0h rdy %0h want 0 0 0", o_ird, o_iaddr, o_rdy);
        end
        tick();
        ack_vld = 1'b1; rdata = 32'h99;
        #1;
        checks++; if (o_ack !== 1'b0 || o_ird !== 1'b0 || o_srst !== 1'b0 || o_rdy !== 1'b0) begin
            failures++; $display("FAIL rm_next: got ack %0h rd %0h srst %0h rdy %0h want 0 0 0 0",
                                 o_ack, o_ird, o_srst, o_rdy);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (o_rdy !== 1'b1 || o_ack !== 1'b0 || o_ireq !== 1'b0) begin
            failures++; $display("FAIL rm_after: got rdy %0h ack %0h req %0h want 1 0 0", o_rdy, o_ack, o_ireq);
        end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b0 || o_err !== 1'b0) begin
            failures++; $display("FAIL rm_no_resp: got ack %0h err %0h want 0 0", o_ack, o_err);
        end
    endtask

    task automatic test_ack_vs_expiry();
        sel = 1'b1;
        apply_reset();
        req_vld = 1'b1; rd_en = 1'b1; addr = 64'h80;
        tick();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            tick();
        end
        tick();
        ack_vld = 1'b1; rdata = 32'h600D_F00D;
        #1;
        checks++; if (o_srst !== 1'b0) begin failures++; $display("FAIL ae_srst_ack: got %0h want 0", o_srst); end
        tick();
        idle_inputs();
        #1;
        checks++; if (o_ack !== 1'b1 || o_err !== 1'b0 || o_rdata !== 32'h600D_F00D || o_srst !== 1'b0) begin
            failures++; $display("FAIL ae_resp: got ack %0h err %0h data %0h srst %0h want 1 0 600df00d 0",
                                 o_ack, o_err, o_rdata, o_srst);
        end
        tick();
        #1;
        checks++; if (o_srst !== 1'b0 || o_ack !== 1'b0) begin
            failures++; $display("FAIL ae_after: got srst %0h ack %0h want 0 0", o_srst, o_ack);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel      = 1'b0;
        rst      = 1'b1;
        idle_inputs();
        test_reset();
        test_write();
        test_read_wait();
        test_read_err();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
        test_ack_vs_expiry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule
